// File: rtl/sobel_seq_if.sv
// Avalon-MM master bus between the Sobel pixel sequencer and memory.
// Request, address and write data are held while m_waitrequest is high.
interface sobel_seq_if;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_waitrequest;
  logic        m_readdatavalid;

  modport master (
    output m_address, m_read, m_write, m_writedata,
    input  m_readdata, m_waitrequest, m_readdatavalid
  );

  modport slave (
    input  m_address, m_read, m_write, m_writedata,
    output m_readdata, m_waitrequest, m_readdatavalid
  );
endinterface

// File: rtl/sobel_pixel_sequencer.sv
// Walks startpixel..endpixel: fetch each word, hand it to the Sobel core, write the result at +RESULT_OFFSET.
// Define SOBEL_SEQ_TIMEOUT_EN to add a core_done watchdog of TIMEOUT_CYC cycles.
module sobel_pixel_sequencer #(
  parameter logic [31:0] RESULT_OFFSET = 32'h0010_0000,
  parameter int          TIMEOUT_CYC   = 1024
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] startpixel,
  input  logic [31:0] endpixel,
  input  logic [31:0] control,
  output logic [31:0] status,
  sobel_seq_if.master bus,
  output logic        core_start,
  output logic [31:0] core_pixel,
  input  logic        core_done,
  input  logic [31:0] core_result
);

  typedef enum logic [2:0] {IDLE, CHECK, RD_REQ, RD_WAIT, CORE, WR_REQ, NEXT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] start_q, start_d;
  logic [31:0] end_q, end_d;
  logic [31:0] pixel_q, pixel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [23:0] count_q, count_d;
  logic        go_dly_q, go_dly_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        range_err_q, range_err_d;
  logic        aborted_q, aborted_d;
  logic        abort_pend_q, abort_pend_d;
  logic        core_start_q, core_start_d;
  logic        go_edge;
  logic        abort;
  logic        timeout_bit;
  logic        unused_ctrl;

  if (TIMEOUT_CYC < 1) begin : g_timeout_chk
    $error("TIMEOUT_CYC must be at least 1");
  end

`ifdef SOBEL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q, timeout_d;
  assign timeout_bit = timeout_q;
`else
  assign timeout_bit = 1'b0;
`endif

  assign go_edge     = control[0] & ~go_dly_q;
  assign abort       = control[1];
  assign unused_ctrl = ^control[31:2];

  assign status          = {count_q, 3'b000, timeout_bit, aborted_q, range_err_q, done_q, busy_q};
  assign core_start      = core_start_q;
  assign core_pixel      = pixel_q;
  assign bus.m_writedata = wdata_q;

  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    start_d         = start_q;
    end_d           = end_q;
    pixel_d         = pixel_q;
    wdata_d         = wdata_q;
    count_d         = count_q;
    go_dly_d        = control[0];
    busy_d          = busy_q;
    done_d          = done_q;
    range_err_d     = range_err_q;
    aborted_d       = aborted_q;
    abort_pend_d    = abort_pend_q;
    core_start_d    = 1'b0;
    bus.m_read      = 1'b0;
    bus.m_write     = 1'b0;
    bus.m_address   = 32'h0;
`ifdef SOBEL_SEQ_TIMEOUT_EN
    tmo_cnt_d       = tmo_cnt_q;
    timeout_d       = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (go_edge) begin
          // Range is latched here so register writes mid-run cannot disturb it.
          state_d     = CHECK;
          done_d      = 1'b0;
          range_err_d = 1'b0;
          aborted_d   = 1'b0;
          count_d     = 24'h0;
          start_d     = startpixel;
          end_d       = endpixel;
`ifdef SOBEL_SEQ_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
        end
      end
      CHECK: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (start_q > end_q) begin
          range_err_d = 1'b1;
          done_d      = 1'b1;
          state_d     = IDLE;
        end else begin
          busy_d     = 1'b1;
          cur_addr_d = start_q;
          state_d    = RD_REQ;
        end
      end
      RD_REQ: begin
        bus.m_read    = 1'b1;
        bus.m_address = cur_addr_q;
        if (!bus.m_waitrequest) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // An abort seen while the read is outstanding waits for its data, then drops it.
        if (bus.m_readdatavalid) begin
          abort_pend_d = 1'b0;
          if (abort || abort_pend_q) begin
            busy_d    = 1'b0;
            aborted_d = 1'b1;
            done_d    = 1'b0;
            state_d   = IDLE;
          end else begin
            pixel_d      = bus.m_readdata;
            core_start_d = 1'b1;
            state_d      = CORE;
`ifdef SOBEL_SEQ_TIMEOUT_EN
            tmo_cnt_d    = '0;
`endif
          end
        end else if (abort) begin
          abort_pend_d = 1'b1;
        end
      end
      CORE: begin
        if (abort) begin
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          done_d    = 1'b0;
          state_d   = IDLE;
        end else if (core_done) begin
          wdata_d = core_result;
          state_d = WR_REQ;
        end
`ifdef SOBEL_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      WR_REQ: begin
        bus.m_write   = 1'b1;
        bus.m_address = cur_addr_q + RESULT_OFFSET;
        if (!bus.m_waitrequest) begin
          count_d = (count_q == 24'hFF_FFFF) ? count_q : count_q + 24'd1;
          state_d = NEXT;
        end
      end
      NEXT: begin
        // Compare before increment so an end of 32'hFFFF_FFFF never wraps.
        if (abort) begin
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          done_d    = 1'b0;
          state_d   = IDLE;
        end else if (cur_addr_q == end_q) begin
          state_d = DONE;
        end else begin
          cur_addr_d = cur_addr_q + 32'd1;
          state_d    = RD_REQ;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= 32'h0;
      start_q      <= 32'h0;
      end_q        <= 32'h0;
      pixel_q      <= 32'h0;
      wdata_q      <= 32'h0;
      count_q      <= 24'h0;
      go_dly_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      range_err_q  <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      core_start_q <= 1'b0;
`ifdef SOBEL_SEQ_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      start_q      <= start_d;
      end_q        <= end_d;
      pixel_q      <= pixel_d;
      wdata_q      <= wdata_d;
      count_q      <= count_d;
      go_dly_q     <= go_dly_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      range_err_q  <= range_err_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
      core_start_q <= core_start_d;
`ifdef SOBEL_SEQ_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_sobel_pixel_sequencer.sv
// Bench for sobel_pixel_sequencer: memory and Sobel-core models on the negative edge,
// scoreboard queues of expected reads/writes filled per run and drained by the memory model.
module tb_sobel_pixel_sequencer;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        n_rst;
  logic [31:0] startpixel;
  logic [31:0] endpixel;
  logic [31:0] control;
  logic [31:0] status;
  logic        core_start;
  logic [31:0] core_pixel;
  logic        core_done;
  logic [31:0] core_result;

  sobel_seq_if bus ();

  sobel_pixel_sequencer #(
    .RESULT_OFFSET (32'h0010_0000),
    .TIMEOUT_CYC   (16)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .startpixel  (startpixel),
    .endpixel    (endpixel),
    .control     (control),
    .status      (status),
    .bus         (bus),
    .core_start  (core_start),
    .core_pixel  (core_pixel),
    .core_done   (core_done),
    .core_result (core_result)
  );

  int          tests_run = 0;
  int          failures  = 0;
  int          ws        = 0;
  int          rd_cnt    = 0;
  int          wr_cnt    = 0;
  int          core_starts = 0;
  logic        core_en   = 1'b1;
  logic [31:0] exp_rd_q[$];
  wr_t         exp_wr_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] core_fn(input logic [31:0] p);
    return {p[15:0], p[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  // Expected traffic for a run: n_rd reads from s, the first n_wr of them written back.
  task automatic push_run(input logic [31:0] s, input int n_rd, input int n_wr);
    wr_t w;
    for (int i = 0; i < n_rd; i++) exp_rd_q.push_back(s + 32'(i));
    for (int i = 0; i < n_wr; i++) begin
      w.addr = s + 32'(i) + 32'h0010_0000;
      w.data = core_fn(mem_word(s + 32'(i)));
      exp_wr_q.push_back(w);
    end
  endtask

  task automatic start_go(input logic [31:0] s, input logic [31:0] e);
    @(negedge clk);
    startpixel = s;
    endpixel   = e;
    control[0] = 1'b1;
    @(negedge clk);
    control[0] = 1'b0;
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #2;
      if (!status[0] && status[4:1] != 4'b0) begin
        to = 1'b0;
        break;
      end
    end
    repeat (4) @(negedge clk);
    #2;
  endtask

  // Memory slave: decides waitrequest each cycle, returns read data one cycle after acceptance.
  initial begin : slave_model
    int          wcnt;
    logic [31:0] req_addr;
    logic        req_wr;
    logic        rd_pend;
    logic [31:0] rd_addr;
    logic [31:0] ea;
    wr_t         w;
    wcnt = 0; req_addr = 32'h0; req_wr = 1'b0; rd_pend = 1'b0; rd_addr = 32'h0;
    bus.m_waitrequest = 1'b0; bus.m_readdatavalid = 1'b0; bus.m_readdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.m_readdatavalid = rd_pend;
      bus.m_readdata      = rd_pend ? mem_word(rd_addr) : 32'h0;
      rd_pend             = 1'b0;
      if (!n_rst) begin
        wcnt = 0;
        bus.m_waitrequest   = 1'b0;
        bus.m_readdatavalid = 1'b0;
      end else if (bus.m_read || bus.m_write) begin
        if (wcnt == 0) begin
          req_addr = bus.m_address;
          req_wr   = bus.m_write;
        end else begin
          tests_run++;
          if (bus.m_address !== req_addr || bus.m_write !== req_wr || bus.m_read !== ~req_wr) begin
            failures++;
            $display("FAIL req_hold: addr=0x%08h wr=%0b rd=%0b, required addr=0x%08h wr=%0b held",
                     bus.m_address, bus.m_write, bus.m_read, req_addr, req_wr);
          end
        end
        if (wcnt < ws) begin
          bus.m_waitrequest = 1'b1;
          wcnt++;
        end else begin
          bus.m_waitrequest = 1'b0;
          wcnt = 0;
          tests_run++;
          if (bus.m_read && bus.m_write) begin
            failures++;
            $display("FAIL bus_exclusive: m_read=1 m_write=1, required never both high");
          end else if (bus.m_read) begin
            rd_cnt++;
            if (exp_rd_q.size() == 0) begin
              failures++;
              $display("FAIL rd_addr: unexpected read at 0x%08h, required no read", bus.m_address);
            end else begin
              ea = exp_rd_q.pop_front();
              if (bus.m_address !== ea) begin
                failures++;
                $display("FAIL rd_addr: got 0x%08h, required 0x%08h", bus.m_address, ea);
              end
            end
            rd_pend = 1'b1;
            rd_addr = bus.m_address;
          end else begin
            wr_cnt++;
            if (exp_wr_q.size() == 0) begin
              failures++;
              $display("FAIL wr_addr: unexpected write at 0x%08h, required no write", bus.m_address);
            end else begin
              w = exp_wr_q.pop_front();
              if (bus.m_address !== w.addr || bus.m_writedata !== w.data) begin
                failures++;
                $display("FAIL wr_txn: got 0x%08h/0x%08h, required 0x%08h/0x%08h",
                         bus.m_address, bus.m_writedata, w.addr, w.data);
              end
            end
          end
        end
      end else begin
        bus.m_waitrequest = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Sobel core: result three cycles after core_start.
  initial begin : core_model
    int          cnt;
    logic [31:0] pix;
    cnt = 0; pix = 32'h0;
    core_done = 1'b0; core_result = 32'h0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (!n_rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            core_done   = core_en;
            core_result = core_fn(pix);
          end
        end
        if (core_start) begin
          cnt = 3;
          pix = core_pixel;
          core_starts++;
        end
      end
    end
  end

  task automatic test_reset();
    n_rst = 1'b0; startpixel = 32'h0; endpixel = 32'h0; control = 32'h0;
    repeat (3) @(negedge clk);
    #2;
    tests_run++;
    if (status !== 32'h0) begin failures++; $display("FAIL reset_status: got 0x%08h, required 0x00000000", status); end
    tests_run++;
    if (bus.m_read !== 1'b0 || bus.m_write !== 1'b0) begin
      failures++; $display("FAIL reset_req: rd=%0b wr=%0b, required 0/0", bus.m_read, bus.m_write);
    end
    tests_run++;
    if (bus.m_address !== 32'h0 || bus.m_writedata !== 32'h0) begin
      failures++; $display("FAIL reset_bus: addr=0x%08h wdata=0x%08h, required 0/0", bus.m_address, bus.m_writedata);
    end
    tests_run++;
    if (core_start !== 1'b0 || core_pixel !== 32'h0) begin
      failures++; $display("FAIL reset_core: start=%0b pixel=0x%08h, required 0/0", core_start, core_pixel);
    end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    int r0, w0, c0;
    ws = 0; r0 = rd_cnt; w0 = wr_cnt; c0 = core_starts;
    push_run(32'h10, 3, 3);
    start_go(32'h10, 32'h12);
    #2;
    tests_run++;
    if (bus.m_read !== 1'b0) begin failures++; $display("FAIL basic_lat1: m_read=%0b one cycle after go, required 0", bus.m_read); end
    @(negedge clk); #2;
    tests_run++;
    if (bus.m_read !== 1'b1 || bus.m_address !== 32'h10) begin
      failures++; $display("FAIL basic_lat2: m_read=%0b addr=0x%08h two cycles after go, required 1/0x00000010", bus.m_read, bus.m_address);
    end
    wait_idle(to);
    tests_run++;
    if (to !== 1'b0) begin failures++; $display("FAIL basic_finish: timed out=%0b, required 0", to); end
    tests_run++;
    if (status !== 32'h0000_0302) begin failures++; $display("FAIL basic_status: got 0x%08h, required 0x00000302", status); end
    tests_run++;
    if (rd_cnt - r0 != 3 || wr_cnt - w0 != 3 || core_starts - c0 != 3) begin
      failures++; $display("FAIL basic_counts: rd=%0d wr=%0d core=%0d, required 3/3/3", rd_cnt - r0, wr_cnt - w0, core_starts - c0);
    end
  endtask

  task automatic test_single();
    bit to;
    int r0, w0;
    ws = 0; r0 = rd_cnt; w0 = wr_cnt;
    push_run(32'h40, 1, 1);
    start_go(32'h40, 32'h40);
    wait_idle(to);
    tests_run++;
    if (to !== 1'b0 || status !== 32'h0000_0102) begin
      failures++; $display("FAIL single_status: got 0x%08h (to=%0b), required 0x00000102", status, to);
    end
    tests_run++;
    if (rd_cnt - r0 != 1 || wr_cnt - w0 != 1) begin
      failures++; $display("FAIL single_counts: rd=%0d wr=%0d, required 1/1", rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_range_err();
    bit to;
    int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    start_go(32'h20, 32'h1F);
    wait_idle(to);
    tests_run++;
    if (to !== 1'b0 || status !== 32'h0000_0006) begin
      failures++; $display("FAIL range_status: got 0x%08h (to=%0b), required 0x00000006", status, to);
    end
    tests_run++;
    if (rd_cnt != r0 || wr_cnt != w0) begin
      failures++; $display("FAIL range_traffic: rd=%0d wr=%0d, required 0/0", rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_waitstates();
    bit to;
    int r0, w0;
    ws = 4; r0 = rd_cnt; w0 = wr_cnt;
    push_run(32'h30, 2, 2);
    start_go(32'h30, 32'h31);
    wait_idle(to);
    ws = 0;
    tests_run++;
    if (to !== 1'b0 || status !== 32'h0000_0202) begin
      failures++; $display("FAIL ws_status: got 0x%08h (to=%0b), required 0x00000202", status, to);
    end
    tests_run++;
    if (rd_cnt - r0 != 2 || wr_cnt - w0 != 2) begin
      failures++; $display("FAIL ws_counts: rd=%0d wr=%0d, required 2/2", rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_abort();
    bit to;
    bit found;
    int r0, w0, c0;
    ws = 4; r0 = rd_cnt; w0 = wr_cnt; c0 = core_starts; found = 1'b0;
    push_run(32'h50, 2, 1);
    start_go(32'h50, 32'h53);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk); #2;
      if (bus.m_read && bus.m_address == 32'h51 && bus.m_waitrequest) begin
        found = 1'b1;
        control[1] = 1'b1;
        break;
      end
    end
    tests_run++;
    if (found !== 1'b1) begin failures++; $display("FAIL abort_window: second read stalled=%0b, required 1", found); end
    wait_idle(to);
    control[1] = 1'b0;
    ws = 0;
    tests_run++;
    if (to !== 1'b0 || status !== 32'h0000_0108) begin
      failures++; $display("FAIL abort_status: got 0x%08h (to=%0b), required 0x00000108", status, to);
    end
    tests_run++;
    if (rd_cnt - r0 != 2 || wr_cnt - w0 != 1 || core_starts - c0 != 1) begin
      failures++; $display("FAIL abort_counts: rd=%0d wr=%0d core=%0d, required 2/1/1", rd_cnt - r0, wr_cnt - w0, core_starts - c0);
    end
  endtask

  task automatic test_go_abort_same();
    bit to;
    int r0;
    r0 = rd_cnt;
    @(negedge clk);
    startpixel = 32'h44; endpixel = 32'h45; control = 32'h3;
    @(negedge clk);
    control = 32'h2;
    @(negedge clk);
    control = 32'h0;
    wait_idle(to);
    tests_run++;
    if (to !== 1'b0 || status !== 32'h0000_0008 || rd_cnt != r0) begin
      failures++; $display("FAIL go_abort: status 0x%08h reads %0d (to=%0b), required 0x00000008 and 0", status, rd_cnt - r0, to);
    end
  endtask

  task automatic test_wrap();
    bit to;
    ws = 0;
    push_run(32'hFFFF_FFFE, 2, 2);
    start_go(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    wait_idle(to);
    tests_run++;
    if (to !== 1'b0 || status !== 32'h0000_0202) begin
      failures++; $display("FAIL wrap_status: got 0x%08h (to=%0b), required 0x00000202", status, to);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int r0, w0;
    ws = 0; r0 = rd_cnt; w0 = wr_cnt;
    push_run(32'h80, 4, 4);
    start_go(32'h80, 32'h83);
    repeat (10) @(negedge clk);
    control[0] = 1'b1;
    @(negedge clk);
    control[0] = 1'b0;
    wait_idle(to);
    tests_run++;
    if (to !== 1'b0 || status !== 32'h0000_0402) begin
      failures++; $display("FAIL b2b_first: got 0x%08h (to=%0b), required 0x00000402", status, to);
    end
    tests_run++;
    if (rd_cnt - r0 != 4 || wr_cnt - w0 != 4) begin
      failures++; $display("FAIL b2b_counts: rd=%0d wr=%0d, required 4/4", rd_cnt - r0, wr_cnt - w0);
    end
    push_run(32'h90, 1, 1);
    start_go(32'h90, 32'h90);
    wait_idle(to);
    tests_run++;
    if (to !== 1'b0 || status !== 32'h0000_0102) begin
      failures++; $display("FAIL b2b_second: got 0x%08h (to=%0b), required 0x00000102", status, to);
    end
  endtask

`ifdef SOBEL_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit to;
    int k;
    core_en = 1'b0; k = -1;
    exp_rd_q.push_back(32'h60);
    start_go(32'h60, 32'h60);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #2;
      if (core_start) begin k = 0; break; end
    end
    for (int c = 0; c < 200 && k >= 0; c++) begin
      @(negedge clk); #2;
      k++;
      if (status[4]) break;
    end
    tests_run++;
    if (k != 16) begin failures++; $display("FAIL timeout_cycles: timeout after %0d cycles in CORE, required 16", k); end
    wait_idle(to);
    tests_run++;
    if (to !== 1'b0 || status !== 32'h0000_0010) begin
      failures++; $display("FAIL timeout_status: got 0x%08h (to=%0b), required 0x00000010", status, to);
    end
    core_en = 1'b1;
    push_run(32'h70, 2, 2);
    start_go(32'h70, 32'h71);
    wait_idle(to);
    tests_run++;
    if (to !== 1'b0 || status !== 32'h0000_0202) begin
      failures++; $display("FAIL timeout_rerun: got 0x%08h (to=%0b), required 0x00000202", status, to);
    end
  endtask
`endif

  task automatic test_reset_midrun();
    int r0;
    r0 = rd_cnt;
    push_run(32'hA0, 6, 6);
    start_go(32'hA0, 32'hA5);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #2;
      if (rd_cnt - r0 >= 2 && bus.m_read) break;
    end
    n_rst = 1'b0;
    #1;
    tests_run++;
    if (bus.m_read !== 1'b0 || bus.m_write !== 1'b0 || status !== 32'h0) begin
      failures++; $display("FAIL reset_midrun: rd=%0b wr=%0b status=0x%08h, required 0/0/0", bus.m_read, bus.m_write, status);
    end
    repeat (2) @(negedge clk);
    exp_rd_q.delete();
    exp_wr_q.delete();
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_range_err();
    test_waitstates();
    test_abort();
    test_go_abort_same();
    test_wrap();
    test_back_to_back();
`ifdef SOBEL_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    tests_run++;
    if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
      failures++; $display("FAIL sb_drain: %0d reads %0d writes outstanding, required 0/0", exp_rd_q.size(), exp_wr_q.size());
    end
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
